// File: rtl/frame_fifo_ctrl.sv
// Pointer/status controller for the matrix-operand FIFO with N*N frame sequencing.
// Define FRAME_FIFO_ALMOST_EN to add the almost_full / almost_empty outputs.
module frame_fifo_ctrl #(
  parameter int ADDR_W = 5,
  parameter int N_W    = 4,
  parameter int AF_TH  = (1 << ADDR_W) - 2,
  parameter int AE_TH  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic              clear,
  input  logic [N_W-1:0]    n,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              wr_en,
  output logic              rd_en,
  output logic [ADDR_W:0]   level,
  output logic              empty,
  output logic              full,
  output logic              frame_ready,
  output logic              push_err,
  output logic              pop_err,
  output logic              cfg_err
`ifdef FRAME_FIFO_ALMOST_EN
  ,
  output logic              almost_full,
  output logic              almost_empty
`endif
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int PW    = ADDR_W + 1;
  localparam int SW    = 2 * N_W;

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_READY, S_DRAIN} state_t;

  state_t        r_state;
  state_t        w_state_nx;
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [PW-1:0] r_cnt;
  logic [PW-1:0] r_frame_n_sq;
  logic [PW-1:0] w_cnt_nx;
  logic [PW-1:0] w_frame_n_sq_nx;
  logic [PW-1:0] w_cnt_inc;
  logic          r_push_err;
  logic          r_pop_err;
  logic          r_cfg_err;
  logic          w_push_err_nx;
  logic          w_pop_err_nx;
  logic          w_cfg_err_nx;
  logic [SW-1:0] w_sq;
  logic          w_sq_ok;
  logic          w_empty;
  logic          w_full;

  assign w_sq      = SW'(n) * SW'(n);
  assign w_sq_ok   = (w_sq != '0) && (32'(w_sq) <= DEPTH);
  assign w_cnt_inc = r_cnt + PW'(1);

  // Wrap-bit pointers: equal means empty, equal low bits with differing MSB means full
  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[ADDR_W-1:0] == r_rd_ptr[ADDR_W-1:0]) &&
                   (r_wr_ptr[ADDR_W] != r_rd_ptr[ADDR_W]);

  always_comb begin
    w_state_nx      = r_state;
    w_cnt_nx        = r_cnt;
    w_frame_n_sq_nx = r_frame_n_sq;
    w_push_err_nx   = 1'b0;
    w_pop_err_nx    = 1'b0;
    w_cfg_err_nx    = 1'b0;
    wr_en           = 1'b0;
    rd_en           = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_pop_err_nx = pop;
        if (push) begin
          if (!w_sq_ok) begin
            w_cfg_err_nx = 1'b1;
          end else if (w_full) begin
            w_push_err_nx = 1'b1;
          end else begin
            wr_en           = 1'b1;
            w_frame_n_sq_nx = PW'(w_sq);
            w_cnt_nx        = PW'(1);
            w_state_nx      = (w_sq == SW'(1)) ? S_READY : S_FILL;
          end
        end
      end
      S_FILL: begin
        w_pop_err_nx = pop;
        if (push) begin
          if (w_full) begin
            w_push_err_nx = 1'b1;
          end else begin
            wr_en    = 1'b1;
            w_cnt_nx = w_cnt_inc;
            if (w_cnt_inc == r_frame_n_sq) w_state_nx = S_READY;
          end
        end
      end
      S_READY: begin
        w_push_err_nx = push;
        if (pop) begin
          if (w_empty) begin
            w_pop_err_nx = 1'b1;
          end else begin
            rd_en = 1'b1;
            // A single-entry frame is fully drained by its first pop
            if (r_frame_n_sq == PW'(1)) begin
              w_cnt_nx   = '0;
              w_state_nx = S_IDLE;
            end else begin
              w_cnt_nx   = PW'(1);
              w_state_nx = S_DRAIN;
            end
          end
        end
      end
      S_DRAIN: begin
        w_push_err_nx = push;
        if (pop) begin
          if (w_empty) begin
            w_pop_err_nx = 1'b1;
          end else begin
            rd_en = 1'b1;
            if (w_cnt_inc == r_frame_n_sq) begin
              w_cnt_nx   = '0;
              w_state_nx = S_IDLE;
            end else begin
              w_cnt_nx = w_cnt_inc;
            end
          end
        end
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      r_state      <= S_IDLE;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_cnt        <= '0;
      r_frame_n_sq <= '0;
      r_push_err   <= 1'b0;
      r_pop_err    <= 1'b0;
      r_cfg_err    <= 1'b0;
    end else begin
      r_state      <= w_state_nx;
      r_wr_ptr     <= r_wr_ptr + PW'(wr_en);
      r_rd_ptr     <= r_rd_ptr + PW'(rd_en);
      r_cnt        <= w_cnt_nx;
      r_frame_n_sq <= w_frame_n_sq_nx;
      r_push_err   <= w_push_err_nx;
      r_pop_err    <= w_pop_err_nx;
      r_cfg_err    <= w_cfg_err_nx;
    end
  end

  assign wr_addr     = r_wr_ptr[ADDR_W-1:0];
  assign rd_addr     = r_rd_ptr[ADDR_W-1:0];
  assign level       = r_wr_ptr - r_rd_ptr;
  assign empty       = w_empty;
  assign full        = w_full;
  assign frame_ready = (r_state == S_READY) || (r_state == S_DRAIN);
  assign push_err    = r_push_err;
  assign pop_err     = r_pop_err;
  assign cfg_err     = r_cfg_err;

`ifdef FRAME_FIFO_ALMOST_EN
  assign almost_full  = (32'(level) >= AF_TH);
  assign almost_empty = (32'(level) <= AE_TH);
`else
  logic w_unused_th;
  assign w_unused_th = ^{AF_TH[0], AE_TH[0]};
`endif

endmodule

// File: tb/tb_frame_fifo_ctrl.sv
// Directed bench for frame_fifo_ctrl: a 32-deep instance and a 16-deep instance.
module tb_frame_fifo_ctrl;

  logic clk;
  logic rst, clear;
  logic push5, pop5, push4, pop4;
  logic [3:0] n5, n4;

  logic [4:0] wr_addr5, rd_addr5;
  logic [5:0] level5;
  logic wr_en5, rd_en5, empty5, full5, fr5, push_err5, pop_err5, cfg_err5;

  logic [3:0] wr_addr4, rd_addr4;
  logic [4:0] level4;
  logic wr_en4, rd_en4, empty4, full4, fr4, push_err4, pop_err4, cfg_err4;

  int compared = 0;
  int mismatched = 0;
  logic seen_full;

  frame_fifo_ctrl #(.ADDR_W(5), .N_W(4)) dut5 (
    .clk(clk), .rst(rst), .push(push5), .pop(pop5), .clear(clear), .n(n5),
    .wr_addr(wr_addr5), .rd_addr(rd_addr5), .wr_en(wr_en5), .rd_en(rd_en5),
    .level(level5), .empty(empty5), .full(full5), .frame_ready(fr5),
    .push_err(push_err5), .pop_err(pop_err5), .cfg_err(cfg_err5)
  );

  frame_fifo_ctrl #(.ADDR_W(4), .N_W(4)) dut4 (
    .clk(clk), .rst(rst), .push(push4), .pop(pop4), .clear(clear), .n(n4),
    .wr_addr(wr_addr4), .rd_addr(rd_addr4), .wr_en(wr_en4), .rd_en(rd_en4),
    .level(level4), .empty(empty4), .full(full4), .frame_ready(fr4),
    .push_err(push_err4), .pop_err(pop_err4), .cfg_err(cfg_err4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; clear = 1'b0;
    push5 = 1'b0; pop5 = 1'b0; n5 = 4'd0;
    push4 = 1'b0; pop4 = 1'b0; n4 = 4'd0;
    tick();
    tick();
    rst = 1'b0;

    // reset state, both instances
    chk("rst_level5", 32'(level5), 0);
    chk("rst_empty5", 32'(empty5), 1);
    chk("rst_full5", 32'(full5), 0);
    chk("rst_ready5", 32'(fr5), 0);
    chk("rst_errs5", 32'({push_err5, pop_err5, cfg_err5}), 0);
    chk("rst_addr5", 32'({wr_addr5, rd_addr5}), 0);
    chk("rst_en5", 32'({wr_en5, rd_en5}), 0);
    chk("rst_level4", 32'(level4), 0);
    chk("rst_flags4", 32'({empty4, full4, fr4}), 32'b100);
    chk("rst_errs4", 32'({push_err4, pop_err4, cfg_err4}), 0);
    chk("rst_addr4", 32'({wr_addr4, rd_addr4}), 0);
    chk("rst_en4", 32'({wr_en4, rd_en4}), 0);

    // pop in IDLE is rejected
    pop5 = 1'b1;
    #1 chk("idle_pop_rd_en", 32'(rd_en5), 0);
    tick();
    pop5 = 1'b0;
    chk("idle_pop_err", 32'(pop_err5), 1);
    tick();
    chk("idle_pop_err_clr", 32'(pop_err5), 0);

    // n=3: nine pushes then nine pops
    n5 = 4'd3;
    for (int i = 0; i < 9; i++) begin
      push5 = 1'b1;
      #1;
      chk("f3_wr_en", 32'(wr_en5), 1);
      chk("f3_wr_addr", 32'(wr_addr5), i);
      if (i == 8) chk("f3_not_ready_yet", 32'(fr5), 0);
      tick();
    end
    push5 = 1'b0;
    chk("f3_ready", 32'(fr5), 1);
    chk("f3_level", 32'(level5), 9);
    for (int i = 0; i < 9; i++) begin
      pop5 = 1'b1;
      #1;
      chk("f3_rd_en", 32'(rd_en5), 1);
      chk("f3_rd_addr", 32'(rd_addr5), i);
      if (i == 8) chk("f3_ready_drain", 32'(fr5), 1);
      tick();
    end
    pop5 = 1'b0;
    chk("f3_empty", 32'(empty5), 1);
    chk("f3_ready_off", 32'(fr5), 0);
    chk("f3_level0", 32'(level5), 0);

    // invalid n: 6*6=36 > 32, and n=0
    do_reset();
    n5 = 4'd6;
    push5 = 1'b1;
    #1 chk("n6_wr_en", 32'(wr_en5), 0);
    tick();
    push5 = 1'b0;
    chk("n6_cfg_err", 32'(cfg_err5), 1);
    chk("n6_push_err", 32'(push_err5), 0);
    chk("n6_empty", 32'(empty5), 1);
    chk("n6_wr_addr", 32'(wr_addr5), 0);
    tick();
    chk("n6_cfg_err_clr", 32'(cfg_err5), 0);
    n5 = 4'd0;
    push5 = 1'b1;
    tick();
    push5 = 1'b0;
    chk("n0_cfg_err", 32'(cfg_err5), 1);
    chk("n0_level", 32'(level5), 0);
    chk("n0_ready", 32'(fr5), 0);

    // 16-deep instance: n=4 fills it exactly, 17th push rejected
    n4 = 4'd4;
    for (int i = 0; i < 16; i++) begin
      push4 = 1'b1;
      tick();
    end
    push4 = 1'b0;
    chk("d16_full", 32'(full4), 1);
    chk("d16_level", 32'(level4), 16);
    chk("d16_ready", 32'(fr4), 1);
    push4 = 1'b1;
    #1 chk("d16_wr_en17", 32'(wr_en4), 0);
    tick();
    push4 = 1'b0;
    chk("d16_push_err", 32'(push_err4), 1);
    chk("d16_level_hold", 32'(level4), 16);
    tick();
    chk("d16_push_err_clr", 32'(push_err4), 0);

    // n=5: three back-to-back frames, pointers wrap to 75 mod 64 = 11
    do_reset();
    n5 = 4'd5;
    seen_full = 1'b0;
    for (int f = 0; f < 3; f++) begin
      for (int i = 0; i < 25; i++) begin
        push5 = 1'b1;
        #1;
        if (i == 0) chk("f5_start_addr", 32'(wr_addr5), (25 * f) % 32);
        if (full5) seen_full = 1'b1;
        tick();
      end
      push5 = 1'b0;
      chk("f5_ready", 32'(fr5), 1);
      chk("f5_level", 32'(level5), 25);
      for (int i = 0; i < 25; i++) begin
        pop5 = 1'b1;
        #1;
        if (full5) seen_full = 1'b1;
        tick();
      end
      pop5 = 1'b0;
      chk("f5_empty", 32'(empty5), 1);
      chk("f5_never_full", 32'(seen_full), 0);
    end
    chk("f5_wr_wrap", 32'(wr_addr5), 11);
    chk("f5_rd_wrap", 32'(rd_addr5), 11);

    // simultaneous push+pop in FILL and in DRAIN (n=2, frame of 4)
    do_reset();
    n5 = 4'd2;
    push5 = 1'b1;
    tick();
    pop5 = 1'b1;
    #1;
    chk("fill_both_wr_en", 32'(wr_en5), 1);
    chk("fill_both_rd_en", 32'(rd_en5), 0);
    tick();
    pop5 = 1'b0;
    chk("fill_both_pop_err", 32'(pop_err5), 1);
    chk("fill_both_push_err", 32'(push_err5), 0);
    chk("fill_both_level", 32'(level5), 2);
    tick();
    tick();
    push5 = 1'b0;
    chk("fill_done_ready", 32'(fr5), 1);
    chk("fill_done_level", 32'(level5), 4);
    pop5 = 1'b1;
    tick();
    push5 = 1'b1;
    #1;
    chk("drain_both_rd_en", 32'(rd_en5), 1);
    chk("drain_both_wr_en", 32'(wr_en5), 0);
    tick();
    push5 = 1'b0; pop5 = 1'b0;
    chk("drain_both_push_err", 32'(push_err5), 1);
    chk("drain_both_pop_err", 32'(pop_err5), 0);
    chk("drain_both_level", 32'(level5), 2);

    // clear mid-DRAIN at level 4, asserted together with push and pop
    do_reset();
    n5 = 4'd3;
    push5 = 1'b1;
    repeat (9) tick();
    push5 = 1'b0;
    pop5 = 1'b1;
    repeat (5) tick();
    pop5 = 1'b0;
    chk("mid_level4", 32'(level5), 4);
    clear = 1'b1; push5 = 1'b1; pop5 = 1'b1;
    tick();
    clear = 1'b0; push5 = 1'b0; pop5 = 1'b0;
    chk("clr_level", 32'(level5), 0);
    chk("clr_empty", 32'(empty5), 1);
    chk("clr_ready", 32'(fr5), 0);
    chk("clr_errs", 32'({push_err5, pop_err5, cfg_err5}), 0);
    // back in IDLE: n=1 frame goes straight to READY
    n5 = 4'd1;
    push5 = 1'b1;
    tick();
    push5 = 1'b0;
    chk("n1_ready", 32'(fr5), 1);
    chk("n1_level", 32'(level5), 1);
    pop5 = 1'b1;
    tick();
    pop5 = 1'b0;
    chk("n1_idle", 32'(fr5), 0);
    chk("n1_empty", 32'(empty5), 1);

    // rst mid-DRAIN at level 4
    n5 = 4'd3;
    push5 = 1'b1;
    repeat (9) tick();
    push5 = 1'b0;
    pop5 = 1'b1;
    repeat (5) tick();
    pop5 = 1'b0;
    chk("mid2_level4", 32'(level5), 4);
    do_reset();
    chk("rst_mid_level", 32'(level5), 0);
    chk("rst_mid_empty", 32'(empty5), 1);
    chk("rst_mid_ready", 32'(fr5), 0);
    pop5 = 1'b1;
    tick();
    pop5 = 1'b0;
    chk("rst_mid_idle_pop_err", 32'(pop_err5), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/frame_fifo_ctrl.md
Name: frame_fifo_ctrl

Overview:
- Parametrised pointer/status controller for the matrix-operand FIFO; next generation of the fixed-depth push/pop pointer block.
- Tracks wrap-bit read/write pointers over a 2^ADDR_W-deep RAM and reports level, empty, full and errors.
- Adds frame sequencing: buffers exactly N*N operands, raises frame_ready, then drains that frame before accepting the next.
- Sits between the serial operand loader (push side) and the matrix datapath (pop side).

Parameters:
- ADDR_W, 5, RAM address width; DEPTH = 2^ADDR_W entries.
- N_W, 4, width of the matrix-dimension input n.
- AF_TH, DEPTH-2, almost_full threshold, active when level >= AF_TH (optional feature).
- AE_TH, 2, almost_empty threshold, active when level <= AE_TH (optional feature).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset; synchronous, active-high.
- push  in  1  write request.
- pop  in  1  read request.
- clear  in  1  synchronous flush; same effect as rst on all state.
- n  in  N_W  matrix dimension; sampled on the IDLE->FILL transition.
- wr_addr  out  ADDR_W  RAM write address, low bits of wr_ptr.
- rd_addr  out  ADDR_W  RAM read address, low bits of rd_ptr.
- wr_en  out  1  effective push this cycle; combinational.
- rd_en  out  1  effective pop this cycle; combinational.
- level  out  ADDR_W+1  entries held.
- empty  out  1  level == 0.
- full  out  1  level == DEPTH.
- frame_ready  out  1  a complete N*N frame is buffered.
- push_err  out  1  one-cycle pulse; push rejected.
- pop_err  out  1  one-cycle pulse; pop rejected.
- cfg_err  out  1  one-cycle pulse; n invalid at frame start.

Behaviour:
- Reset or clear: wr_ptr = rd_ptr = 0, level 0, state IDLE, frame_n_sq 0, cnt 0, all error outputs 0.
  - empty = 1, full = 0, frame_ready = 0.
  - clear has priority over push and pop in the same cycle.
- Pointers are ADDR_W+1 bits and wrap modulo 2^(ADDR_W+1).
  - empty = (wr_ptr == rd_ptr).
  - full = low bits equal and MSBs differ.
  - level = wr_ptr - rd_ptr, computed modulo 2^(ADDR_W+1).
- Frame size: sq = n*n computed at 2*N_W bits. A frame is valid when 1 <= sq <= DEPTH.
- State IDLE:
  - push with valid sq: latch frame_n_sq = sq, accept the push (wr_en = 1), cnt = 1, go FILL.
  - If sq == 1, go directly to READY instead.
  - push with invalid sq (n = 0 or sq > DEPTH): no pointer movement, cfg_err = 1 next cycle, stay IDLE.
  - pop in IDLE: pop_err.
- State FILL:
  - push accepted when !full; cnt increments.
  - The push that makes cnt == frame_n_sq moves state to READY. frame_ready = 1 from the next cycle.
  - pop in FILL: pop_err, no pointer movement.
- State READY: frame_ready = 1.
  - First pop (accepted when !empty) clears cnt to 1 and moves to DRAIN.
  - push in READY: push_err.
- State DRAIN: frame_ready stays 1.
  - Each pop increments cnt.
  - The pop that makes cnt == frame_n_sq returns to IDLE; frame_ready = 0 from the next cycle.
  - push in DRAIN: push_err.
- wr_en / rd_en are never both 1 in the same cycle.
  - Simultaneous push and pop: the request not valid for the current state is rejected with its error pulse; the other is processed normally.
- Error pulses are registered, asserted for the one cycle following the offending request.
- n changes outside IDLE are ignored.
- Reset mid-frame discards the frame; the RAM contents are don't-care.

Optional Feature:
- Macro: FRAME_FIFO_ALMOST_EN.
- Defined: adds outputs almost_full (level >= AF_TH) and almost_empty (level <= AE_TH), both combinational and 0/1 after reset.
- Undefined: those ports and their logic are absent, and AF_TH/AE_TH are unused.
- All other behaviour is identical either way.

Test Plan:
- ADDR_W=5, n=3, push 9 cycles -> wr_addr 0..8; frame_ready=1 the cycle after the 9th push. Then pop 9 -> rd_addr 0..8, empty=1, frame_ready=0, state IDLE.
- ADDR_W=4, n=4, push 16 -> full=1, level=16, frame_ready=1. A 17th push -> push_err pulse, level stays 16.
- n=6 at ADDR_W=5 (36 > 32) or n=0, push -> cfg_err pulse, wr_ptr stays 0, empty=1.
- ADDR_W=5, n=5, three full frames back-to-back -> wr_ptr/rd_ptr wrap 50->75 mod 64 = 11. After each drain, empty=1 and full is never set.
- push and pop together in FILL -> push accepted, pop_err pulse. Together in DRAIN -> pop accepted, push_err pulse.
- rst or clear in the middle of DRAIN (level=4) -> next cycle level=0, empty=1, frame_ready=0, state IDLE.
